// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiplier and restoring divider,
// one op in flight, valid/ready on both sides, with flush and W-variant support.
module mdu_iter #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TAG_W   = 5,
  parameter bit          WORD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpRem    = 3'b110;

  // W ops only exist on a 64-bit datapath
  localparam bit WordOk = WORD_EN && (XLEN == 64);

  localparam logic [XLEN-1:0] MinFull = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MinWord = ~XLEN'(32'h7fff_ffff);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              fix_q, fix_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Operand preparation for the accept edge
  logic              word_eff;
  logic              a_signed, b_signed;
  logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs;
  logic              a_neg, b_neg;
  logic              div_zero, sovf, word_mulh, fast;
  logic [XLEN-1:0]   fast_raw, fast_val;

  always_comb begin
    word_eff  = WordOk && in_word;
    a_signed  = (in_op == OpMulh) || (in_op == OpMulhsu) || (in_op == OpDiv) || (in_op == OpRem);
    b_signed  = (in_op == OpMulh) || (in_op == OpDiv) || (in_op == OpRem);
    a_ext     = in_a;
    b_ext     = in_b;
    if (word_eff) begin
      a_ext = a_signed ? sext32(in_a[31:0]) : XLEN'(in_a[31:0]);
      b_ext = b_signed ? sext32(in_b[31:0]) : XLEN'(in_b[31:0]);
    end
    a_neg     = a_signed && a_ext[XLEN-1];
    b_neg     = b_signed && b_ext[XLEN-1];
    a_abs     = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_abs     = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_zero  = in_op[2] && (b_ext == '0);
    sovf      = ((in_op == OpDiv) || (in_op == OpRem)) && (b_ext == '1) &&
                (a_ext == (word_eff ? MinWord : MinFull));
    word_mulh = word_eff && !in_op[2] && (in_op[1:0] != 2'b00);
    fast      = div_zero || sovf || word_mulh;
    fast_raw  = '0;
    if (div_zero)  fast_raw = in_op[1] ? a_ext : '1;
    else if (sovf) fast_raw = in_op[1] ? '0 : a_ext;
    fast_val  = word_eff ? sext32(fast_raw[31:0]) : fast_raw;
  end

  // One iteration step of each datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rs, div_diff;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    div_rs   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_rs - {1'b0, opa_q};
  end

  // Sign fixup and result selection on entry to DONE
  logic [2*XLEN-1:0] prod, prod_fix, prod_sh;
  logic [XLEN-1:0]   mul_res, div_res, fin_raw, fin_val;

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = qneg_q ? (~prod + 1'b1) : prod;
    // Word products were built 32 positions too high in the 2*XLEN register
    prod_sh  = word_q ? (prod_fix >> 32) : prod_fix;
    mul_res  = (op_q[1:0] == 2'b00) ? prod_sh[XLEN-1:0] : prod_sh[2*XLEN-1:XLEN];
    if (op_q[1]) div_res = rneg_q ? (~hi_q + 1'b1) : hi_q;
    else         div_res = qneg_q ? (~lo_q + 1'b1) : lo_q;
    fin_raw  = op_q[2] ? div_res : mul_res;
    fin_val  = word_q ? sext32(fin_raw[31:0]) : fin_raw;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fix_d   = fix_q;
    op_d    = op_q;
    word_d  = word_q;
    tag_d   = tag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    opa_d   = opa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          op_d   = in_op;
          word_d = word_eff;
          tag_d  = in_tag;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          hi_d   = '0;
          cnt_d  = word_eff ? CntW'(31) : CntW'(XLEN - 1);
          fix_d  = 1'b0;
          if (in_op[2]) begin
            opa_d = b_abs;
            // Left-align a word dividend so its MSB is shifted out first
            lo_d  = word_eff ? (a_abs << 32) : a_abs;
          end else begin
            opa_d = a_abs;
            lo_d  = b_abs;
          end
          if (fast) begin
            res_d   = fast_val;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else if (fix_q) begin
          res_d   = fin_val;
          state_d = StDone;
        end else begin
          if (op_q[2]) begin
            if (!div_diff[XLEN]) hi_d = div_diff[XLEN-1:0];
            else                 hi_d = div_rs[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q - 1'b1;
          fix_d = (cnt_q == '0);
        end
      end
      StDone: begin
        if (flush || out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fix_q   <= 1'b0;
      op_q    <= '0;
      word_q  <= 1'b0;
      tag_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      opa_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fix_q   <= fix_d;
      op_q    <= op_d;
      word_q  <= word_d;
      tag_q   <= tag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      opa_q   <= opa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == StIdle);
    busy       = (state_q != StIdle);
    out_valid  = (state_q == StDone);
    out_result = res_q;
    out_tag    = tag_q;
  end

  logic unused_op;
  assign unused_op = ^{OpMul};

endmodule
